// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 16x oversampling UART receiver for 5-8 bit frames with optional
// parity. Decoded characters and their error flags go into a show-ahead FIFO
// with a valid/ready read port, and an RTS-style output throttles the sender.
module uart_rx_sink #(
    parameter int DEPTH       = 16,
    parameter int RTS_THRESH  = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [15:0]              baud_div,
    input  logic [1:0]               data_bits,
    input  logic                     par_en,
    input  logic                     par_even,
    input  logic                     sin,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [7:0]               m_data,
    output logic                     m_pe,
    output logic                     m_fe,
    output logic                     m_brk,
    output logic                     overrun,
    output logic                     rts_n,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sin_s;
    logic [15:0]            cnt_q, cnt_d, div_m1;
    logic                   tick;
    state_t                 state_q, state_d;
    logic [3:0]             sc_q, sc_d;
    logic [2:0]             bidx_q, bidx_d, last_idx;
    logic [7:0]             data_q, data_d;
    logic [1:0]             cfg_bits_q, cfg_bits_d;
    logic                   cfg_pen_q, cfg_pen_d;
    logic                   cfg_peven_q, cfg_peven_d;
    logic                   par_q, par_d;
    logic                   pe_q, pe_d;
    logic                   stop_fe, stop_brk;
    logic                   push;
    logic [10:0]            push_entry;
    logic [10:0]            mem [DEPTH];
    logic [10:0]            head;
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [LW-1:0]          level_q, level_d;
    logic                   full, pop, push_ok;
    logic                   overrun_q, rts_n_q;

    assign sin_s = sync_q[SYNC_STAGES-1];

    // Synchronize the asynchronous serial line; idle-high reset avoids a false start.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
    end

    // Free-running 16x tick: reload with baud_div-1 (0 behaves as 1) when reaching 0.
    always_comb begin
        div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
        tick   = (cnt_q == 16'd0);
        cnt_d  = tick ? div_m1 : cnt_q - 16'd1;
    end

    // Tick down-counter register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign last_idx = 3'd4 + {1'b0, cfg_bits_q};

    // Frame decoder next-state logic; samples mid-bit and builds the FIFO entry at mid-stop.
    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        bidx_d      = bidx_q;
        data_d      = data_q;
        cfg_bits_d  = cfg_bits_q;
        cfg_pen_d   = cfg_pen_q;
        cfg_peven_d = cfg_peven_q;
        par_d       = par_q;
        pe_d        = pe_q;
        stop_fe     = 1'b0;
        stop_brk    = 1'b0;
        push        = 1'b0;
        push_entry  = '0;
        case (state_q)
            S_IDLE: begin
                if (!sin_s) begin
                    state_d     = S_START;
                    sc_d        = 4'd0;
                    bidx_d      = 3'd0;
                    data_d      = 8'h00;
                    par_d       = 1'b0;
                    pe_d        = 1'b0;
                    cfg_bits_d  = data_bits;
                    cfg_pen_d   = par_en;
                    cfg_peven_d = par_even;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sc_q == 4'd7) begin
                        if (sin_s) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            sc_d    = 4'd0;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        data_d[bidx_q] = sin_s;
                        if (bidx_q == last_idx) state_d = cfg_pen_q ? S_PARITY : S_STOP;
                        else                    bidx_d  = bidx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        par_d   = sin_s;
                        pe_d    = ((^data_q) ^ sin_s) != ~cfg_peven_q;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'd15) begin
                        stop_fe    = ~sin_s;
                        stop_brk   = stop_fe && (data_q == 8'h00) && (!cfg_pen_q || !par_q);
                        push       = 1'b1;
                        push_entry = {stop_brk, stop_fe, pe_q, stop_brk ? 8'h00 : data_q};
                        state_d    = stop_fe ? S_WAIT_IDLE : S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (sin_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame decoder state registers; reset drops any partial character.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            sc_q        <= '0;
            bidx_q      <= '0;
            data_q      <= '0;
            cfg_bits_q  <= '0;
            cfg_pen_q   <= 1'b0;
            cfg_peven_q <= 1'b0;
            par_q       <= 1'b0;
            pe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            bidx_q      <= bidx_d;
            data_q      <= data_d;
            cfg_bits_q  <= cfg_bits_d;
            cfg_pen_q   <= cfg_pen_d;
            cfg_peven_q <= cfg_peven_d;
            par_q       <= par_d;
            pe_q        <= pe_d;
        end
    end

    // FIFO control: a push into a full FIFO only lands when the head leaves that cycle.
    always_comb begin
        full    = (level_q == LW'(DEPTH));
        pop     = m_valid && m_ready;
        push_ok = push && (!full || pop);
        level_d = level_q;
        if (push_ok && !pop)      level_d = level_q + LW'(1);
        else if (!push_ok && pop) level_d = level_q - LW'(1);
    end

    // FIFO storage; contents need no reset since level gates the read side.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= push_entry;
    end

    // FIFO pointers, occupancy, overrun pulse and flow control.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            rts_n_q   <= 1'b1;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop)     rptr_q <= rptr_q + AW'(1);
            level_q   <= level_d;
            overrun_q <= push && full && !pop;
            rts_n_q   <= (level_d >= LW'(RTS_THRESH));
        end
    end

    assign head    = mem[rptr_q];
    assign m_valid = (level_q != '0);
    assign m_data  = m_valid ? head[7:0] : 8'h00;
    assign m_pe    = m_valid & head[8];
    assign m_fe    = m_valid & head[9];
    assign m_brk   = m_valid & head[10];
    assign overrun = overrun_q;
    assign rts_n   = rts_n_q;
    assign level   = level_q;
    assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink at baud_div=4 (64 clks per bit).
module tb_uart_rx_sink;

    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst_;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        par_en, par_even, sin, m_ready;
    logic        m_valid, m_pe, m_fe, m_brk, overrun, rts_n, rx_busy;
    logic [7:0]  m_data;
    logic [4:0]  level;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int ovr_base;

    uart_rx_sink #(.DEPTH(16), .RTS_THRESH(14), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_(rst_), .baud_div(baud_div), .data_bits(data_bits),
        .par_en(par_en), .par_even(par_even), .sin(sin),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_pe(m_pe), .m_fe(m_fe), .m_brk(m_brk), .overrun(overrun),
        .rts_n(rts_n), .level(level), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit);
        sin = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            sin = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (pen) begin
            sin = pbit;
            repeat (BIT) @(negedge clk);
        end
        sin = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (m_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(m_valid), 32'd1);
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        rst_ = 1'b0; sin = 1'b1; m_ready = 1'b0;
        baud_div = 16'd4; data_bits = 2'b11; par_en = 1'b0; par_even = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_level",   32'(level),   32'd0);
        check("rst_rts_n",   32'(rts_n),   32'd1);
        check("rst_busy",    32'(rx_busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_m_data",  32'(m_data),  32'h00);
        rst_ = 1'b1;
        @(negedge clk);
        check("rts_after_rel", 32'(rts_n), 32'd0);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0);
        wait_valid("a5_valid");
        check("a5_data",  32'(m_data), 32'hA5);
        check("a5_flags", 32'({m_brk, m_fe, m_pe}), 32'd0);
        check("a5_level", 32'(level),  32'd1);
        pop_one();
        check("a5_drained", 32'(level), 32'd0);

        // 7E1 0x35: even parity bit is 0; first send it flipped
        data_bits = 2'b10; par_en = 1'b1; par_even = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b1);
        wait_valid("p_bad_valid");
        check("p_bad_data", 32'(m_data), 32'h35);
        check("p_bad_pe",   32'(m_pe),   32'd1);
        check("p_bad_fe",   32'(m_fe),   32'd0);
        pop_one();
        send_frame(8'h35, 7, 1'b1, 1'b0);
        wait_valid("p_ok_valid");
        check("p_ok_data", 32'(m_data), 32'h35);
        check("p_ok_pe",   32'(m_pe),   32'd0);
        pop_one();

        // glitch shorter than half a bit
        data_bits = 2'b11; par_en = 1'b0;
        sin = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_hi", 32'(rx_busy), 32'd1);
        repeat (10) @(negedge clk);
        sin = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_lo", 32'(rx_busy), 32'd0);
        check("glitch_level",   32'(level),   32'd0);

        // break: 12 bit-times low
        sin = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        check("brk_level_low", 32'(level),   32'd1);
        check("brk_wait_idle", 32'(rx_busy), 32'd1);
        sin = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        check("brk_busy_lo", 32'(rx_busy), 32'd0);
        check("brk_level",   32'(level),   32'd1);
        check("brk_data",    32'(m_data),  32'h00);
        check("brk_flags",   32'({m_brk, m_fe, m_pe}), 32'b110);
        pop_one();
        check("brk_drained", 32'(level), 32'd0);

        // fill and overrun
        ovr_base = ovr_cnt;
        for (int n = 1; n <= 17; n++) begin
            send_frame(8'(n - 1), 8, 1'b0, 1'b0);
            check($sformatf("fill_level_%0d", n), 32'(level), (n <= 16) ? 32'(n) : 32'd16);
            check($sformatf("fill_rts_%0d", n), 32'(rts_n), (n >= 14) ? 32'd1 : 32'd0);
            if (n == 16) check("ovr_before", 32'(ovr_cnt - ovr_base), 32'd0);
        end
        check("ovr_after", 32'(ovr_cnt - ovr_base), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(m_valid), 32'd1);
            check($sformatf("drain_data_%0d", i),  32'(m_data),  32'(i));
            pop_one();
            if (i == 1) check("drain_rts_14", 32'(rts_n), 32'd1);
            if (i == 2) check("drain_rts_13", 32'(rts_n), 32'd0);
        end
        check("drain_level", 32'(level),   32'd0);
        check("drain_valid", 32'(m_valid), 32'd0);

        // reset mid-frame with one entry still queued
        send_frame(8'h11, 8, 1'b0, 1'b0);
        check("pre_rst_level", 32'(level), 32'd1);
        sin = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sin = (8'h5A >> i) & 8'h01;
            repeat (BIT) @(negedge clk);
        end
        check("mid_busy", 32'(rx_busy), 32'd1);
        rst_ = 1'b0;
        sin  = 1'b1;
        #1;
        check("mrst_valid",  32'(m_valid), 32'd0);
        check("mrst_level",  32'(level),   32'd0);
        check("mrst_busy",   32'(rx_busy), 32'd0);
        check("mrst_rts_n",  32'(rts_n),   32'd1);
        check("mrst_data",   32'(m_data),  32'h00);
        check("mrst_ovr",    32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h3C, 8, 1'b0, 1'b0);
        wait_valid("3c_valid");
        check("3c_data",  32'(m_data), 32'h3C);
        check("3c_flags", 32'({m_brk, m_fe, m_pe}), 32'd0);
        check("3c_level", 32'(level),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
